demux_1to2_6: RTL and testbench

DEMUX_1TO2_6 -- requirements
Module: demux_1to2_6

---
 rtl/demux_1to2_6_pkg.sv | 17 +
 rtl/demux_fifo.sv | 61 ++++++
 rtl/demux_1to2_6.sv | 103 ++++++++++
 tb/tb_demux_1to2_6.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/demux_1to2_6_pkg.sv
// demux_1to2_6_pkg -- shared datapath constants for the 1-to-2 demultiplexer.
//   DMX_WIDTH : default word width (6-bit register-address datapath)
//   DMX_DEPTH : default entries per output queue (power of two, >= 2)
//   DMX_CNT_W : width of the per-destination accept counters
package demux_1to2_6_pkg;

  localparam int DMX_WIDTH = 6;
  localparam int DMX_DEPTH = 2;
  localparam int DMX_CNT_W = 8;

  // Destination encoding carried on the select input.
  typedef enum logic {
    DST_OUT0 = 1'b0,
    DST_OUT1 = 1'b1
  } dmx_dst_e;

endpackage

// File: rtl/demux_fifo.sv
// demux_fifo -- small synchronous FIFO used as one output queue of the demux.
//   clk, reset     : clock, asynchronous active-high reset (clears storage too)
//   push, wdata    : write request and data (ignored while full)
//   pop, rdata     : read request (ignored while empty) and head-of-queue data
//   empty, full    : occupancy flags, derived from the registered count
//   count          : occupancy, log2(DEPTH)+1 bits
module demux_fifo
  import demux_1to2_6_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int DEPTH = DMX_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // A full queue refuses a push even when it pops in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage is cleared on reset so the head reads as zero while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;  // wraps modulo DEPTH (power of two)
      end
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to2_6.sv
// demux_1to2_6 -- routes an input word stream to one of two buffered outputs.
//   clk, reset              : clock, asynchronous active-high reset
//   in_data/in_valid/select : incoming word, valid, destination (0->out0, 1->out1)
//   in_ready                : the selected queue has space (independent of in_valid)
//   outN_data/outN_valid    : head of queue N, queue N non-empty
//   outN_ready              : consumer takes the head of queue N
//   cnt0, cnt1              : wrapping 8-bit accept counters per destination,
//                             present only when DEMUX_COUNT_EN is defined
module demux_1to2_6
  import demux_1to2_6_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int DEPTH = DMX_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 select,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_valid,
`ifdef DEMUX_COUNT_EN
  input  logic                 out1_ready,
  output logic [DMX_CNT_W-1:0] cnt0,
  output logic [DMX_CNT_W-1:0] cnt1
`else
  input  logic                 out1_ready
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic          full0, full1, empty0, empty1;
  logic          push0, push1, pop0, pop1, accept;
  logic [AW:0]   count0, count1;

  assign in_ready = (select == DST_OUT1) ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;
  assign push0    = accept & (select == DST_OUT0);
  assign push1    = accept & (select == DST_OUT1);
  assign pop0     = ~empty0 & out0_ready;
  assign pop1     = ~empty1 & out1_ready;

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data),
    .rdata (out0_data),
    .empty (empty0),
    .full  (full0),
    .count (count0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data),
    .rdata (out1_data),
    .empty (empty1),
    .full  (full1),
    .count (count1)
  );

  // Occupancy is only observed through the flags at this level.
  logic unused_cnt;
  assign unused_cnt = ^{count0, count1};

`ifdef DEMUX_COUNT_EN
  logic [DMX_CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push0) cnt0_d = cnt0_q + 1'b1;  // wraps 255 -> 0
    if (push1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1to2_6.sv
// tb_demux_1to2_6 -- directed, scoreboard-based bench for demux_1to2_6.
module tb_demux_1to2_6;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid, select, in_ready;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef DEMUX_COUNT_EN
  logic [7:0]   cnt0, cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rx1     = 0;
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];

  always #5 clk = ~clk;

  demux_1to2_6 dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .select     (select),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
`ifdef DEMUX_COUNT_EN
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`else
    .out1_ready (out1_ready)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: settle inputs, record accepts into the scoreboard, compare
  // popped heads against it, then advance to 1 time unit after the edge.
  task automatic step(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (acc) begin
      if (select) exp1.push_back(in_data);
      else        exp0.push_back(in_data);
    end
    if (out0_valid && out0_ready) begin
      if (exp0.size() == 0) chk("sb0_unexpected", 32'(out0_data), 32'hFFFF_FFFF);
      else                  chk("sb0_data", 32'(out0_data), 32'(exp0.pop_front()));
    end
    if (out1_valid && out1_ready) begin
      rx1++;
      if (exp1.size() == 0) chk("sb1_unexpected", 32'(out1_data), 32'hFFFF_FFFF);
      else                  chk("sb1_data", 32'(out1_data), 32'(exp1.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int idx, guard;
    logic [W-1:0] held;

    reset = 1'b1; in_data = '0; in_valid = 1'b0; select = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_in_ready",   32'(in_ready),   1);
    chk("rst_out0_data",  32'(out0_data),  0);
    chk("rst_out1_data",  32'(out1_data),  0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Routing
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; select = 1'b0; in_data = 6'b001101;
    step(acc);
    chk("route_acc0", 32'(acc), 1);
    chk("route_out0_valid", 32'(out0_valid), 1);
    chk("route_out0_data", 32'(out0_data), 32'(6'b001101));
    select = 1'b1; in_data = 6'b110010;
    step(acc);
    chk("route_out1_valid", 32'(out1_valid), 1);
    chk("route_out1_data", 32'(out1_data), 32'(6'b110010));
    chk("route_out0_drained", 32'(out0_valid), 0);
    in_valid = 1'b0;
    step(acc);
    chk("route_out1_drained", 32'(out1_valid), 0);

    // Full queue 0, other destination still open
    out0_ready = 1'b0; in_valid = 1'b1; select = 1'b0;
    in_data = 6'd11; step(acc); chk("full_acc1", 32'(acc), 1);
    held = out0_data;
    in_data = 6'd22; step(acc); chk("full_acc2", 32'(acc), 1);
    in_data = 6'd33; #1;
    chk("full_in_ready0", 32'(in_ready), 0);
    step(acc); chk("full_acc3", 32'(acc), 0);
    chk("hold_data", 32'(out0_data), 32'(held));
    chk("hold_valid", 32'(out0_valid), 1);
    select = 1'b1; #1;
    chk("full_other_ready", 32'(in_ready), 1);
    step(acc); chk("full_other_acc", 32'(acc), 1);
    chk("full_other_out1", 32'(out1_data), 32'(6'd33));

    // Full queue with simultaneous pop: push refused, then accepted
    select = 1'b0; in_data = 6'd44; out0_ready = 1'b1; #1;
    chk("fpop_ready_lo", 32'(in_ready), 0);
    step(acc); chk("fpop_refused", 32'(acc), 0);
    chk("fpop_ready_hi", 32'(in_ready), 1);
    step(acc); chk("fpop_accepted", 32'(acc), 1);
    in_valid = 1'b0;
    guard = 0;
    while ((out0_valid || out1_valid) && guard < 20) begin step(acc); guard++; end
    chk("fpop_drain", 32'(guard < 20), 1);
    chk("fpop_sb_empty", 32'(exp0.size() + exp1.size()), 0);

    // Order and pointer wrap on out1 with toggling ready
    rx1 = 0; idx = 0; guard = 0; select = 1'b1;
    while (idx < 10 && guard < 100) begin
      in_valid = 1'b1; in_data = W'(idx);
      out1_ready = ~out1_ready;
      step(acc);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    while (out1_valid && guard < 200) begin
      out1_ready = ~out1_ready; step(acc); guard++;
    end
    chk("order_timeout", 32'(guard < 200), 1);
    chk("order_rx_count", 32'(rx1), 10);
    chk("order_sb_empty", 32'(exp1.size()), 0);

    // Reset mid-stream discards contents
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    select = 1'b0; in_data = 6'h2A; step(acc);
    select = 1'b1; in_data = 6'h15; step(acc);
    in_valid = 1'b0;
    #2 reset = 1'b1; #1;
    chk("mrst_out0_valid", 32'(out0_valid), 0);
    chk("mrst_out1_valid", 32'(out1_valid), 0);
    chk("mrst_in_ready",   32'(in_ready),   1);
    chk("mrst_out0_data",  32'(out0_data),  32'(6'b000000));
    exp0.delete(); exp1.delete();
    @(posedge clk); #1;
    reset = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    step(acc); step(acc);
    chk("mrst_no_deliver", 32'({out0_valid, out1_valid}), 0);

`ifdef DEMUX_COUNT_EN
    reset = 1'b1; #1; reset = 1'b0;
    in_valid = 1'b1; select = 1'b0; idx = 0; guard = 0;
    while (idx < 257 && guard < 1000) begin
      in_data = W'(idx); step(acc);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("cnt_timeout", 32'(guard < 1000), 1);
    chk("cnt0_wrap", 32'(cnt0), 1);
    chk("cnt1_zero", 32'(cnt1), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
